// File: rtl/men_wb.sv
// MEM->WB pipeline stage: registers the writeback payload, drives the register-bank
// write port, sources execute-stage forwarding and counts retired instructions.
module men_wb #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              Valido_Entrada,
   input  logic              BR_Hab_Escrita_Entrada,
   input  logic              controleMUX_WB,
   input  logic [REG_AW-1:0] Endereco_Destino,
   input  logic [DATA_W-1:0] Saida_ULA,
   input  logic [DATA_W-1:0] Saida_MemoriaDados,
   input  logic [REG_AW-1:0] Consulta_A,
   input  logic [REG_AW-1:0] Consulta_B,
   output logic              BR_Hab_Escrita,
   output logic [REG_AW-1:0] BR_Endereco,
   output logic [DATA_W-1:0] BR_Dado,
   output logic              Valido,
   output logic              Adiantar_A,
   output logic              Adiantar_B,
   output logic [15:0]       Contador_Retirados
);

   logic              valid_q;
   logic              we_q;
   logic              sel_q;
   logic [REG_AW-1:0] dest_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] mem_q;
   logic [15:0]       count_q;

   // Flush only kills the control bits; the data words are don't-care in a bubble.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 1'b0;
         dest_q  <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         count_q <= '0;
      end else if (Flush) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
      end else if (!Stall) begin
         valid_q <= Valido_Entrada;
         we_q    <= BR_Hab_Escrita_Entrada;
         sel_q   <= controleMUX_WB;
         dest_q  <= Endereco_Destino;
         alu_q   <= Saida_ULA;
         mem_q   <= Saida_MemoriaDados;
         if (Valido_Entrada) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   logic wr_en;

   // Register 0 is hardwired zero: never written, never forwarded.
   always_comb begin
      wr_en              = valid_q & we_q & (dest_q != '0);
      BR_Hab_Escrita     = wr_en;
      BR_Endereco        = dest_q;
      BR_Dado            = sel_q ? mem_q : alu_q;
      Valido             = valid_q;
      Adiantar_A         = wr_en & (Consulta_A == dest_q);
      Adiantar_B         = wr_en & (Consulta_B == dest_q);
      Contador_Retirados = count_q;
   end

endmodule

// File: tb/tb_men_wb.sv
// Self-checking bench for men_wb: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_men_wb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic        Valido_Entrada = 1'b0;
   logic        BR_Hab_Escrita_Entrada = 1'b0;
   logic        controleMUX_WB = 1'b0;
   logic [2:0]  Endereco_Destino = '0;
   logic [15:0] Saida_ULA = '0;
   logic [15:0] Saida_MemoriaDados = '0;
   logic [2:0]  Consulta_A = '0;
   logic [2:0]  Consulta_B = '0;
   logic        BR_Hab_Escrita;
   logic [2:0]  BR_Endereco;
   logic [15:0] BR_Dado;
   logic        Valido;
   logic        Adiantar_A;
   logic        Adiantar_B;
   logic [15:0] Contador_Retirados;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   men_wb #(.DATA_W(16), .REG_AW(3)) dut (
      .clock(clock), .reset(reset), .Stall(Stall), .Flush(Flush),
      .Valido_Entrada(Valido_Entrada), .BR_Hab_Escrita_Entrada(BR_Hab_Escrita_Entrada),
      .controleMUX_WB(controleMUX_WB), .Endereco_Destino(Endereco_Destino),
      .Saida_ULA(Saida_ULA), .Saida_MemoriaDados(Saida_MemoriaDados),
      .Consulta_A(Consulta_A), .Consulta_B(Consulta_B),
      .BR_Hab_Escrita(BR_Hab_Escrita), .BR_Endereco(BR_Endereco), .BR_Dado(BR_Dado),
      .Valido(Valido), .Adiantar_A(Adiantar_A), .Adiantar_B(Adiantar_B),
      .Contador_Retirados(Contador_Retirados)
   );

   always #5 clock = ~clock;

   // Model: the instruction currently sitting in writeback plus a retired count.
   typedef struct packed {
      logic        valid;
      logic        writes;
      logic        from_mem;
      logic [2:0]  dest;
      logic [15:0] alu;
      logic [15:0] mem;
   } instr_t;

   instr_t held;
   int     retired;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         held    <= '0;
         retired <= 0;
      end else if (Flush) begin
         held.valid  <= 1'b0;
         held.writes <= 1'b0;
      end else if (!Stall) begin
         held <= '{Valido_Entrada, BR_Hab_Escrita_Entrada, controleMUX_WB,
                   Endereco_Destino, Saida_ULA, Saida_MemoriaDados};
         if (Valido_Entrada) retired <= (retired + 1) % 65536;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         logic        e_we;
         e_we = held.valid && held.writes && (held.dest != 0);
         chk("m_valido", {31'd0, Valido}, {31'd0, held.valid});
         chk("m_hab", {31'd0, BR_Hab_Escrita}, {31'd0, e_we});
         chk("m_end", {29'd0, BR_Endereco}, {29'd0, held.dest});
         chk("m_dado", {16'd0, BR_Dado}, {16'd0, held.from_mem ? held.mem : held.alu});
         chk("m_adA", {31'd0, Adiantar_A}, {31'd0, e_we && (Consulta_A == held.dest)});
         chk("m_adB", {31'd0, Adiantar_B}, {31'd0, e_we && (Consulta_B == held.dest)});
         chk("m_cnt", {16'd0, Contador_Retirados}, retired);
      end
   end

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic sel, input logic [2:0] d,
                        input logic [15:0] alu, input logic [15:0] mem);
      Valido_Entrada = v;
      BR_Hab_Escrita_Entrada = we;
      controleMUX_WB = sel;
      Endereco_Destino = d;
      Saida_ULA = alu;
      Saida_MemoriaDados = mem;
   endtask

   initial begin
      #2;
      chk("reset_valido", {31'd0, Valido}, 0);
      chk("reset_cnt", {16'd0, Contador_Retirados}, 0);
      chk("reset_dado", {16'd0, BR_Dado}, 0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      cmp_en = 1'b1;

      drive(1, 1, 0, 3'd5, 16'hBEEF, 16'h0F0F);
      cyc();
      chk("alu_hab", {31'd0, BR_Hab_Escrita}, 1);
      chk("alu_end", {29'd0, BR_Endereco}, 5);
      chk("alu_dado", {16'd0, BR_Dado}, 32'hBEEF);
      chk("alu_cnt", {16'd0, Contador_Retirados}, 1);

      drive(1, 1, 1, 3'd2, 16'h1111, 16'hA5A5);
      Consulta_A = 3'd2;
      Consulta_B = 3'd4;
      cyc();
      chk("ld_dado", {16'd0, BR_Dado}, 32'hA5A5);
      chk("ld_adA", {31'd0, Adiantar_A}, 1);
      chk("ld_adB", {31'd0, Adiantar_B}, 0);

      drive(1, 1, 0, 3'd0, 16'h7777, 16'h0000);
      Consulta_A = 3'd0;
      cyc();
      chk("r0_hab", {31'd0, BR_Hab_Escrita}, 0);
      chk("r0_adA", {31'd0, Adiantar_A}, 0);
      chk("r0_cnt", {16'd0, Contador_Retirados}, 3);

      drive(1, 1, 0, 3'd6, 16'h6666, 16'h0000);
      Consulta_A = 3'd6;
      cyc();
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 3'(i + 1), 16'($urandom), 16'($urandom));
         cyc();
         chk("stall_hab", {31'd0, BR_Hab_Escrita}, 1);
         chk("stall_end", {29'd0, BR_Endereco}, 6);
         chk("stall_dado", {16'd0, BR_Dado}, 32'h6666);
         chk("stall_cnt", {16'd0, Contador_Retirados}, 4);
      end
      Flush = 1'b1;
      cyc();
      chk("flush_valido", {31'd0, Valido}, 0);
      chk("flush_hab", {31'd0, BR_Hab_Escrita}, 0);
      chk("flush_cnt", {16'd0, Contador_Retirados}, 4);
      Flush = 1'b0;
      Stall = 1'b0;

      drive(1, 1, 0, 3'd3, 16'h1234, 16'h0000);
      Consulta_A = 3'd3;
      cyc();
      chk("pre_rst_dado", {16'd0, BR_Dado}, 32'h1234);
      chk("pre_rst_cnt", {16'd0, Contador_Retirados}, 5);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_valido", {31'd0, Valido}, 0);
      chk("rst_hab", {31'd0, BR_Hab_Escrita}, 0);
      chk("rst_end", {29'd0, BR_Endereco}, 0);
      chk("rst_dado", {16'd0, BR_Dado}, 0);
      chk("rst_adA", {31'd0, Adiantar_A}, 0);
      chk("rst_cnt", {16'd0, Contador_Retirados}, 0);
      @(negedge clock);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         Stall = ($urandom_range(0, 4) == 0);
         Flush = ($urandom_range(0, 9) == 0);
         drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
               16'($urandom), 16'($urandom));
         Consulta_A = 3'($urandom);
         Consulta_B = 3'($urandom);
         cyc();
      end

      Stall = 1'b0;
      Flush = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      drive(1, 1, 0, 3'd1, 16'h0001, 16'h0002);
      repeat (65535) @(posedge clock);
      @(negedge clock);
      #1;
      chk("wrap_ffff", {16'd0, Contador_Retirados}, 32'hFFFF);
      cyc();
      chk("wrap_0000", {16'd0, Contador_Retirados}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/men_wb.md
# men_wb

MEM→WB pipeline stage of the 16-bit datapath. It captures the ALU result, the data-memory read word and the writeback control leaving the execute/memory stage. It selects the writeback value and drives the register-bank write port one cycle later. It also serves as the forwarding source for the execute stage, and keeps a count of retired instructions.

## Interface
Parameters:
- DATA_W, 16, datapath width
- REG_AW, 3, register-bank address width (8 registers, register 0 hardwired zero)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Stall  in  1  hold stage contents
- Flush  in  1  load a bubble
- Valido_Entrada  in  1  incoming instruction is valid
- BR_Hab_Escrita_Entrada  in  1  incoming instruction writes the register bank
- controleMUX_WB  in  1  writeback select: 0 = ALU result, 1 = memory word
- Endereco_Destino  in  REG_AW  destination register
- Saida_ULA  in  DATA_W  ALU result, same cycle
- Saida_MemoriaDados  in  DATA_W  memory read word, same cycle
- Consulta_A, Consulta_B  in  REG_AW  source registers of the instruction in execute
- BR_Hab_Escrita  out  1  register-bank write enable
- BR_Endereco  out  REG_AW  register-bank write address
- BR_Dado  out  DATA_W  register-bank write data
- Valido  out  1  stage holds a valid instruction
- Adiantar_A, Adiantar_B  out  1  forward BR_Dado to operand A / B
- Contador_Retirados  out  16  retired-instruction count

## Operation
- Stage registers: valid, write-enable, select, destination, ALU word, memory word.
- Edge priority: reset > Flush > Stall > load.
- Flush: valid←0 and write-enable←0. Data registers keep their contents; they are don't-care.
- Stall without Flush: all registers hold.
- Load: every register takes its input.
- Writeback mux, combinational from registers: BR_Dado = select ? memory word : ALU word.
- BR_Hab_Escrita = valid & write-enable & (destination ≠ 0).
- BR_Endereco = registered destination.
- Adiantar_X = BR_Hab_Escrita & (Consulta_X == BR_Endereco). Purely combinational on Consulta_X.
- Register 0 is never written and never forwarded.
- Contador_Retirados increments by 1 on every edge that performs a load with Valido_Entrada=1. It does not increment on stall, on flush, or when a bubble is loaded.
- Counter wraps 0xFFFF→0x0000.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on BR_* after edge N.
- The register bank writes at edge N+1. Same-cycle read of that register in execute must use Adiantar_*.
- Reset (async, immediate, in any state including mid-stall):
  - All outputs go to 0: Valido, BR_Hab_Escrita, BR_Endereco, BR_Dado, Adiantar_A/B, Contador_Retirados.
  - Stage data registers clear to 0.
- Reset release: first load occurs on the first rising edge with reset low.
- Stall held for k cycles: outputs are stable for k cycles. While the held instruction is valid, BR_Hab_Escrita stays asserted for all k cycles; the register-bank rewrite of the same value is harmless and required.
- Flush and Stall together: Flush wins; a bubble is loaded.
- No ready/valid backpressure is generated here. Stall and Flush come from the hazard unit.

## Test plan
- Reset mid-operation: load valid ALU instruction (dest 3, Saida_ULA=0x1234), then assert reset asynchronously between edges -> all outputs 0 immediately, counter 0.
- ALU writeback: Valido_Entrada=1, enable=1, select=0, dest=5, Saida_ULA=0xBEEF, mem=0x0F0F -> next cycle BR_Hab_Escrita=1, BR_Endereco=5, BR_Dado=0xBEEF, counter=1.
- Load writeback and forwarding: select=1, dest=2, mem=0xA5A5; Consulta_A=2, Consulta_B=4 -> BR_Dado=0xA5A5, Adiantar_A=1, Adiantar_B=0.
- Register 0 destination: enable=1, dest=0 -> BR_Hab_Escrita=0 and Adiantar_A=0 with Consulta_A=0. The counter still increments.
- Stall, then Flush+Stall: hold valid dest 6 for 3 cycles -> outputs unchanged and counter unchanged. Then Flush=1 with Stall=1 -> Valido=0, BR_Hab_Escrita=0, no increment.
- Counter wrap: drive 65536 consecutive valid loads from reset -> counter reads 0xFFFF after 65535 loads and 0x0000 after the next.
